griffin_stream_adapter: RTL
===========================

GRIFFIN_STREAM_ADAPTER -- requirements
Module: griffin_stream_adapter

Interface
REQ-001 SHALL have parameter N_BITS, default 254: field element width.
REQ-002 SHALL have parameter PRIME_MODULUS, default 254'h30644e72e131a029b85045b68181585d2833e84879b9709143e1f593f0000001: field modulus.
REQ-003 SHALL have parameter STATE_SIZE, default 3: permutation state width.
REQ-004 SHALL have parameter LANES, default 13: batched instances per permutation run.
REQ-005 SHALL have one clock and an asynchronous active-low reset: clk  in  1  rising-edge clock; reset_n  in  1  async active-low reset.
REQ-006 SHALL have s_valid  in  1, s_ready  out  1, s_data  in  N_BITS: input element stream.
REQ-007 SHALL have m_valid  out  1, m_ready  in  1, m_data  out  N_BITS, m_last  out  1: output element stream.
REQ-008 SHALL have core_enable  out  1, core_in  out  N_BITS x [STATE_SIZE][LANES], core_out  in  N_BITS x [STATE_SIZE][LANES], core_done  in  1: permutation core port.
REQ-009 SHALL have busy  out  1 (core run in flight) and s_err  out  1 (range-violation pulse).

Function
REQ-010 SHALL map stream element j (0..STATE_SIZE*LANES-1 = 38) to [j mod STATE_SIZE][j div STATE_SIZE] on both core_in and output.
REQ-011 SHALL use input FSM FILL -> START -> BUSY -> FILL.
REQ-012 FILL: s_ready=1; each s_valid&&s_ready writes s_data to core_in slot in_cnt and increments in_cnt.
REQ-013 FILL -> START on acceptance of element 38; in_cnt wraps to 0.
REQ-014 START: s_ready=0; core_enable=1 for exactly one cycle only when output buffer empty; otherwise holds in START with core_enable=0.
REQ-015 BUSY: s_ready=0, busy=1; core_in SHALL stay stable from the START cycle until core_done.
REQ-016 core_done (one-cycle pulse) in BUSY: copy all core_out into output buffer, mark full, return to FILL; core_done outside BUSY is ignored.
REQ-017 Output side: m_valid=1 while buffer full; m_data = buffer slot out_cnt; each m_valid&&m_ready increments out_cnt.
REQ-018 m_last=1 when out_cnt==38 and m_valid; handshake on it empties buffer and wraps out_cnt to 0.
REQ-019 m_data/m_valid SHALL hold stable while m_valid && !m_ready.
REQ-020 Filling of the next batch SHALL overlap draining of the previous; START waits per REQ-014.
REQ-021 Buffer empties and core_done coincide: impossible by REQ-014; no priority logic needed.
REQ-022 Latency: first m_valid SHALL be the cycle after core_done.
REQ-023 Throughput: no bubble on s_ready within FILL; no bubble on m_valid within a drain.

Reset
REQ-024 reset_n low SHALL asynchronously force FILL, in_cnt=0, out_cnt=0, buffer empty.
REQ-025 Reset outputs: s_ready=1 after release, m_valid=0, m_last=0, core_enable=0, busy=0, s_err=0; core_in and buffer contents undefined.
REQ-026 Reset mid-batch or mid-run SHALL discard partial input, in-flight run and undrained output; the integrator resets the core concurrently.

Configuration
REQ-027 Macro GRIFFIN_STREAM_RANGE_CHECK_EN defined: accepted element with s_data >= PRIME_MODULUS is consumed (s_ready handshake completes) but not stored, in_cnt unchanged, s_err=1 for that cycle.
REQ-028 Macro undefined: no comparison logic; every accepted element stored; s_err tied 0.

Verification
REQ-029 39 elements j=0..38 with value j+1, m_ready=1, core model returning input+5 after 40 cycles -> one core_enable pulse, 39 outputs j+6 in order, m_last only on 39th.
REQ-030 Element 5 = PRIME_MODULUS, macro defined -> s_err pulse once, element dropped, 40 offered elements yield one batch of 39; macro undefined -> batch completes at element 38 with value stored.
REQ-031 m_ready=0 for 20 cycles after first output -> m_data frozen at slot 0, second batch fills, START holds with core_enable=0 until m_last handshake, then one core_enable pulse.
REQ-032 m_ready toggling 1/0 each cycle -> 39 outputs over 78 cycles, no duplicates or drops.
REQ-033 reset_n low for 1 cycle after 17 elements and during BUSY -> outputs to reset values immediately; next 39 elements form a fresh batch at slot 0.
REQ-034 Spurious core_done in FILL -> ignored, m_valid stays 0.

Source files
------------

// File: rtl/griffin_stream_adapter.sv
// Streams STATE_SIZE*LANES field elements into a batched permutation core and drains its results.
// Define GRIFFIN_STREAM_RANGE_CHECK_EN to drop (and flag on s_err) inputs >= PRIME_MODULUS.
module griffin_stream_adapter #(
  parameter int unsigned       N_BITS        = 254,
  parameter logic [N_BITS-1:0] PRIME_MODULUS =
      254'h30644e72e131a029b85045b68181585d2833e84879b9709143e1f593f0000001,
  parameter int unsigned       STATE_SIZE    = 3,
  parameter int unsigned       LANES         = 13
) (
  input  logic                                         clk,
  input  logic                                         reset_n,
  input  logic                                         s_valid,
  output logic                                         s_ready,
  input  logic [N_BITS-1:0]                            s_data,
  output logic                                         m_valid,
  input  logic                                         m_ready,
  output logic [N_BITS-1:0]                            m_data,
  output logic                                         m_last,
  output logic                                         core_enable,
  output logic [STATE_SIZE-1:0][LANES-1:0][N_BITS-1:0] core_in,
  input  logic [STATE_SIZE-1:0][LANES-1:0][N_BITS-1:0] core_out,
  input  logic                                         core_done,
  output logic                                         busy,
  output logic                                         s_err
);

  localparam int unsigned RowW = (STATE_SIZE > 1) ? $clog2(STATE_SIZE) : 1;
  localparam int unsigned ColW = (LANES > 1) ? $clog2(LANES) : 1;
  localparam logic [RowW-1:0] RowLast = RowW'(STATE_SIZE - 1);
  localparam logic [ColW-1:0] ColLast = ColW'(LANES - 1);

  if (PRIME_MODULUS < 2) begin : g_bad_modulus
    $error("PRIME_MODULUS must be at least 2");
  end

  typedef enum logic [1:0] {StFill, StStart, StBusy} state_e;

  state_e          state_q, state_d;
  logic [RowW-1:0] in_row_q, in_row_d, out_row_q, out_row_d;
  logic [ColW-1:0] in_col_q, in_col_d, out_col_q, out_col_d;
  logic            buf_full_q, buf_full_d;

  logic [STATE_SIZE-1:0][LANES-1:0][N_BITS-1:0] core_in_q, buf_q;

  logic s_hs, store, in_range, in_last, out_last, m_hs, buf_load;

`ifdef GRIFFIN_STREAM_RANGE_CHECK_EN
  assign in_range = (s_data < PRIME_MODULUS);
  assign s_err    = s_hs & ~in_range;
`else
  assign in_range = 1'b1;
  assign s_err    = 1'b0;
`endif

  // Element j lives at [j mod STATE_SIZE][j div STATE_SIZE]: row steps fastest.
  assign s_hs     = s_valid & s_ready;
  assign store    = s_hs & in_range;
  assign in_last  = (in_row_q == RowLast) && (in_col_q == ColLast);
  assign out_last = (out_row_q == RowLast) && (out_col_q == ColLast);
  assign buf_load = (state_q == StBusy) & core_done;

  always_comb begin
    state_d     = state_q;
    in_row_d    = in_row_q;
    in_col_d    = in_col_q;
    s_ready     = 1'b0;
    core_enable = 1'b0;
    busy        = 1'b0;
    unique case (state_q)
      StFill: begin
        s_ready = 1'b1;
        if (store) begin
          if (in_last) begin
            in_row_d = '0;
            in_col_d = '0;
            state_d  = StStart;
          end else if (in_row_q == RowLast) begin
            in_row_d = '0;
            in_col_d = in_col_q + ColW'(1);
          end else begin
            in_row_d = in_row_q + RowW'(1);
          end
        end
      end
      StStart: begin
        // Launch only once the previous results are fully drained.
        if (!buf_full_q) begin
          core_enable = 1'b1;
          state_d     = StBusy;
        end
      end
      StBusy: begin
        busy = 1'b1;
        if (core_done) state_d = StFill;
      end
      default: state_d = StFill;
    endcase
  end

  assign m_valid = buf_full_q;
  assign m_data  = buf_q[out_row_q][out_col_q];
  assign m_last  = buf_full_q & out_last;
  assign m_hs    = m_valid & m_ready;

  always_comb begin
    buf_full_d = buf_full_q;
    out_row_d  = out_row_q;
    out_col_d  = out_col_q;
    if (buf_load) begin
      buf_full_d = 1'b1;
    end else if (m_hs) begin
      if (out_last) begin
        buf_full_d = 1'b0;
        out_row_d  = '0;
        out_col_d  = '0;
      end else if (out_row_q == RowLast) begin
        out_row_d = '0;
        out_col_d = out_col_q + ColW'(1);
      end else begin
        out_row_d = out_row_q + RowW'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= StFill;
      in_row_q   <= '0;
      in_col_q   <= '0;
      out_row_q  <= '0;
      out_col_q  <= '0;
      buf_full_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      in_row_q   <= in_row_d;
      in_col_q   <= in_col_d;
      out_row_q  <= out_row_d;
      out_col_q  <= out_col_d;
      buf_full_q <= buf_full_d;
    end
  end

  // Data storage is not reset; only writes in FILL, so core_in is stable through START/BUSY.
  always_ff @(posedge clk) begin
    if ((state_q == StFill) && store) core_in_q[in_row_q][in_col_q] <= s_data;
    if (buf_load) buf_q <= core_out;
  end

  assign core_in = core_in_q;

endmodule
